// File: rtl/dbus_mem_responder.sv
// Memory-side dbus responder: accepts one request at a time, services it from
// an internal 64-bit-word array after a fixed latency, and returns a one-cycle
// handshake with the registered pre-write word.
module dbus_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [139:0] dreq,
  output logic [65:0]  dresp,
  output logic         range_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  LOAD_CNT = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Request fields, MSB first: valid, addr, size, strobe, data.
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;

  assign req_valid  = dreq[139];
  assign req_addr   = dreq[138:75];
  assign req_size   = dreq[74:72];
  assign req_strobe = dreq[71:64];
  assign req_data   = dreq[63:0];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        capture;
  logic [63:0] addr_q;
  logic [7:0]  strobe_q;
  logic [63:0] wdata_q;
  logic        ok_q;
  logic [63:0] rdata_q;
  logic        range_err_q;

  logic [63:0] mem_q [DEPTH_WORDS] = '{default: '0};

  // Decode uses the incoming address on the accept edge (so LATENCY=1 can read
  // on the same edge it captures) and the captured address afterwards.
  logic [63:0]      sel_addr;
  logic [63:0]      sel_offset;
  logic             sel_in_range;
  logic [IDX_W-1:0] sel_idx;
  logic             enter_resp;

  assign sel_addr     = capture ? req_addr : addr_q;
  assign sel_offset   = sel_addr - BASE_ADDR;
  assign sel_in_range = (sel_addr >= BASE_ADDR) && (sel_offset < SPAN);
  assign sel_idx      = sel_offset[IDX_W+2:3];
  assign enter_resp   = (state_d == RESP) && (state_q != RESP);

  // Size is carried for the initiator only; lanes come from strobe.
  logic unused_bits;
  assign unused_bits = ^{req_size, sel_offset[2:0]};

  // Next-state logic for the IDLE/BUSY/RESP sequencer and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          cnt_d   = LOAD_CNT;
          state_d = (LATENCY > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture; held stable until the transaction retires.
  always_ff @(posedge clk) begin
    if (!reset && capture) begin
      addr_q   <= req_addr;
      strobe_q <= req_strobe;
      wdata_q  <= req_data;
    end
  end

  // Registered response: handshake and pre-write word for exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ok_q        <= 1'b0;
      rdata_q     <= 64'd0;
      range_err_q <= 1'b0;
    end else begin
      ok_q    <= enter_resp;
      rdata_q <= (enter_resp && sel_in_range) ? mem_q[sel_idx] : 64'd0;
      if (enter_resp && !sel_in_range) range_err_q <= 1'b1;
    end
  end

  // Byte-lane write commit at the end of the RESP cycle; dropped on reset or
  // out-of-range.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == RESP) && sel_in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem_q[sel_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign dresp     = {ok_q, ok_q, rdata_q};
  assign range_err = range_err_q;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Directed bench for dbus_mem_responder: two instances (LATENCY 2 and 3) are
// checked every cycle against a transaction-level model, plus literal pins.
module tb_dbus_mem_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 1024;

  logic         clk = 1'b0;
  logic         reset;
  logic [139:0] dreq2, dreq3;
  logic [65:0]  dresp2, dresp3;
  logic         rerr2, rerr3;

  dbus_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) u_l2 (
    .clk(clk), .reset(reset), .dreq(dreq2), .dresp(dresp2), .range_err(rerr2));
  dbus_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .BASE_ADDR(BASE)) u_l3 (
    .clk(clk), .reset(reset), .dreq(dreq3), .dresp(dresp3), .range_err(rerr3));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    bit          oor;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic [63:0] mm0 [logic [63:0]];
  logic [63:0] mm1 [logic [63:0]];
  bit          mrerr0 = 1'b0, mrerr1 = 1'b0;
  logic [63:0] last_data0 = '0, last_data1 = '0;
  int          ok_log0[$], ok_log1[$];
  bit          chk_en = 1'b0;
  int          n_chk = 0, n_fail = 0;

  function automatic void check(string nm, logic [65:0] act, logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int latf(int inst);
    return (inst == 0) ? 2 : 3;
  endfunction

  function automatic logic [139:0] mkreq(bit v, logic [63:0] a, logic [7:0] s, logic [63:0] d);
    return {v, a, 3'd3, s, d};
  endfunction

  function automatic bit in_rng(logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
  endfunction

  function automatic logic [63:0] mrd(int inst, logic [63:0] a);
    logic [63:0] k;
    k = (a - BASE) >> 3;
    if (!in_rng(a)) return 64'd0;
    if (inst == 0) return mm0.exists(k) ? mm0[k] : 64'd0;
    return mm1.exists(k) ? mm1[k] : 64'd0;
  endfunction

  // Model: response due LATENCY-1 edges after the accept edge, carrying the
  // old word; in-range writes then merge the strobed bytes.
  task automatic model_txn(input int inst, input logic [63:0] a, input logic [7:0] s,
                           input logic [63:0] d, input int acc);
    exp_t        e;
    logic [63:0] nw;
    logic [63:0] k;
    e.cyc  = acc + latf(inst) - 1;
    e.data = mrd(inst, a);
    e.oor  = !in_rng(a);
    if (inst == 0) q0.push_back(e); else q1.push_back(e);
    if (in_rng(a)) begin
      nw = e.data;
      for (int i = 0; i < 8; i++) if (s[i]) nw[8*i +: 8] = d[8*i +: 8];
      k = (a - BASE) >> 3;
      if (inst == 0) mm0[k] = nw; else mm1[k] = nw;
    end
  endtask

  task automatic drive(input int inst, input logic [139:0] r);
    if (inst == 0) dreq2 = r; else dreq3 = r;
  endtask

  // One transaction; the request lines are scrambled after acceptance.
  task automatic txn(input int inst, input logic [63:0] a, input logic [7:0] s,
                     input logic [63:0] d, output int acc);
    drive(inst, mkreq(1'b1, a, s, d));
    @(posedge clk); #1;
    acc = cyc;
    drive(inst, mkreq(1'b0, ~a, 8'hFF, ~d));
    model_txn(inst, a, s, d, acc);
    repeat (latf(inst)) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input int inst, input logic [65:0] d, input logic re);
    exp_t        e;
    bit          ok;
    logic [63:0] ed;
    ok = 1'b0;
    ed = 64'd0;
    if (inst == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); ok = 1'b1; end
    if (inst == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); ok = 1'b1; end
    if (ok) begin
      ed = e.data;
      if (e.oor) begin
        if (inst == 0) mrerr0 = 1'b1; else mrerr1 = 1'b1;
      end
    end
    check($sformatf("lat%0d dresp", latf(inst)), d, {ok, ok, ed});
    check($sformatf("lat%0d range_err", latf(inst)), 66'(re), 66'((inst == 0) ? mrerr0 : mrerr1));
    if (d[64]) begin
      if (inst == 0) begin last_data0 = d[63:0]; ok_log0.push_back(cyc); end
      else begin last_data1 = d[63:0]; ok_log1.push_back(cyc); end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, dresp2, rerr2);
      cmp(1, dresp3, rerr3);
    end
  end

  initial begin
    int a, a2, n0;
    // Reset with valid requests present: nothing may be captured.
    reset = 1'b1;
    dreq2 = mkreq(1'b1, BASE + 64'h10, 8'hFF, 64'hBAD);
    dreq3 = mkreq(1'b1, BASE + 64'h10, 8'hFF, 64'hBAD);
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset dresp", dresp2, 66'd0);
    check("reset range_err", 66'(rerr2), 66'd0);
    dreq2 = '0;
    dreq3 = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Read of untouched word: data 0, pulse one edge after acceptance.
    txn(0, BASE + 64'h10, 8'h00, 64'h0, a);
    check("rd0 data", 66'(last_data0), 66'd0);
    check("rd0 ok cycle", 66'(ok_log0[ok_log0.size()-1] - a), 66'd1);
    check("rd0 range_err", 66'(rerr2), 66'd0);

    // Full write returns old value; readback returns new value.
    txn(0, BASE + 64'h10, 8'hFF, 64'h1122334455667788, a);
    check("wr full old data", 66'(last_data0), 66'd0);
    txn(0, BASE + 64'h10, 8'h00, 64'h0, a);
    check("rd after full wr", 66'(last_data0), 66'(64'h1122334455667788));

    // Single byte lane 2.
    txn(0, BASE + 64'h10, 8'h04, 64'h0000_0000_00AA_0000, a);
    check("wr byte old data", 66'(last_data0), 66'(64'h1122334455667788));
    txn(0, BASE + 64'h10, 8'h00, 64'h0, a);
    check("rd after byte wr", 66'(last_data0), 66'(64'h11223344_55AA7788));

    // LATENCY=3: seed a word, then back-to-back reads with valid held high.
    txn(1, BASE + 64'h20, 8'hFF, 64'hCAFE_F00D_0000_1234, a);
    ok_log1.delete();
    dreq3 = mkreq(1'b1, BASE + 64'h20, 8'h00, 64'h0);
    @(posedge clk); #1;
    a = cyc;
    model_txn(1, BASE + 64'h20, 8'h00, 64'h0, a);
    repeat (4) @(posedge clk);
    #1;
    a2 = cyc;
    model_txn(1, BASE + 64'h20, 8'h00, 64'h0, a2);
    dreq3 = '0;
    repeat (4) @(posedge clk);
    #1;
    check("lat3 pulse count", 66'(ok_log1.size()), 66'd2);
    if (ok_log1.size() == 2) begin
      check("lat3 pulse1 cycle", 66'(ok_log1[0] - a), 66'd2);
      check("lat3 pulse2 cycle", 66'(ok_log1[1] - a), 66'd6);
    end
    check("lat3 rd data", 66'(last_data1), 66'(64'hCAFE_F00D_0000_1234));

    // Last in-range word, then an out-of-range write aliasing onto it.
    txn(0, BASE + 64'h1FF8, 8'hFF, 64'h0123_4567_89AB_CDEF, a);
    txn(0, BASE - 64'h8, 8'hFF, 64'hDEAD, a);
    check("oor wr data", 66'(last_data0), 66'd0);
    check("oor range_err", 66'(rerr2), 66'd1);
    repeat (10) @(posedge clk);
    #1;
    check("oor range_err sticky", 66'(rerr2), 66'd1);
    txn(0, BASE + 64'h1FF8, 8'h00, 64'h0, a);
    check("last word intact", 66'(last_data0), 66'(64'h0123_4567_89AB_CDEF));
    txn(0, BASE + 64'h2000, 8'h00, 64'h0, a);
    check("oor rd past end", 66'(last_data0), 66'd0);

    // Write aborted by reset in its BUSY cycle.
    n0 = ok_log0.size();
    dreq2 = mkreq(1'b1, BASE + 64'h10, 8'hFF, 64'hFFFF);
    @(posedge clk); #1;
    reset = 1'b1;
    dreq2 = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    mrerr0 = 1'b0;
    mrerr1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort no data_ok", 66'(ok_log0.size()), 66'(n0));
    check("abort range_err", 66'(rerr2), 66'd0);
    txn(0, BASE + 64'h10, 8'h00, 64'h0, a);
    check("abort rd prior", 66'(last_data0), 66'(64'h11223344_55AA7788));

    repeat (3) @(posedge clk);
    #1;
    check("lat2 queue drained", 66'(q0.size()), 66'd0);
    check("lat3 queue drained", 66'(q1.size()), 66'd0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
